// File: rtl/led_pkg.sv
// Shared constants, level type and saturating decrement for the LED fade stage.
// Imported by led_fade_channel and led_fade_driver.
package led_pkg;

  localparam int LED_CLK_HZ   = 50_000_000;
  localparam int LED_N        = 6;
  localparam int LED_PWM_BITS = 8;

  typedef logic [LED_PWM_BITS-1:0] led_level_t;

  function automatic led_level_t sat_dec(
    input led_level_t lvl,
    input led_level_t step
  );
    return (lvl > step) ? led_level_t'(lvl - step) : '0;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: level register with instant-on / linear fade, optional
// gamma (LED_FADE_GAMMA_EN), and PWM compare.
// Ports: clk_50m, reset, enable, led_in, decay_tick, pwm_cnt -> led_out, level_nz.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = LED_PWM_BITS,
  parameter int DECAY_STEP = 4
) (
  input  logic                clk_50m,
  input  logic                reset,
  input  logic                enable,
  input  logic                led_in,
  input  logic                decay_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                level_nz
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] eff_level;

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;

  // Adding LVL_MAX before the shift pins both ends: 0->0, max->max.
  assign sq = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, level}
            + {{PWM_BITS{1'b0}}, LVL_MAX};
  assign eff_level = PWM_BITS'(sq >> PWM_BITS);
`else
  assign eff_level = level;
`endif

  always_ff @(posedge clk_50m) begin
    if (reset || !enable) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      // A live pattern bit beats a coincident decay tick.
      if (led_in)
        level <= LVL_MAX;
      else if (decay_tick)
        level <= sat_dec(level, STEP);
      led_out <= (eff_level > pwm_cnt);
    end
  end

  assign level_nz = |level;

endmodule

// File: rtl/led_fade_driver.sv
// Comet-style LED fade driver: decay prescaler, shared PWM counter and
// N_LED fade channels. Optional gamma: define LED_FADE_GAMMA_EN.
// Ports: clk_50m, reset, enable, led_in[N_LED] -> led_out[N_LED], active.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int N_LED      = LED_N,
  parameter int PWM_BITS   = LED_PWM_BITS,
  parameter int DECAY_DIV  = LED_CLK_HZ / 1000,
  parameter int DECAY_STEP = 4
) (
  input  logic             clk_50m,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_LED-1:0] led_in,
  output logic [N_LED-1:0] led_out,
  output logic             active
);

  localparam int PW = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DECAY_DIV - 1);
  // pwm_cnt stops one short of LVL_MAX so a full level is always on.
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                decay_tick;
  logic [N_LED-1:0]    level_nz;

  assign decay_tick = (presc == PRESC_LAST);

  always_ff @(posedge clk_50m) begin
    if (reset || !enable) begin
      presc   <= '0;
      pwm_cnt <= '0;
      active  <= 1'b0;
    end else begin
      presc   <= decay_tick ? '0 : presc + 1'b1;
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      active  <= |level_nz;
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk_50m   (clk_50m),
      .reset     (reset),
      .enable    (enable),
      .led_in    (led_in[i]),
      .decay_tick(decay_tick),
      .pwm_cnt   (pwm_cnt),
      .led_out   (led_out[i]),
      .level_nz  (level_nz[i])
    );
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_led_fade_driver;

  localparam int DIV  = 10;
  localparam int STP  = 4;
  localparam int LMAX = 255;

  logic       clk_50m = 1'b0;
  logic       reset   = 1'b1;
  logic       enable  = 1'b1;
  logic [5:0] led_in  = '0;
  logic [5:0] led_out;
  logic       active;
  logic [5:0] led_out_slow;
  logic       active_slow;

  int tests = 0;
  int fails = 0;

  always #5 clk_50m = ~clk_50m;

  led_fade_driver #(
    .N_LED(6), .PWM_BITS(8), .DECAY_DIV(DIV), .DECAY_STEP(STP)
  ) dut (
    .clk_50m(clk_50m),
    .reset  (reset),
    .enable (enable),
    .led_in (led_in),
    .led_out(led_out),
    .active (active)
  );

  // Slow-decay copy so a mid level can be held still for a full PWM period.
  led_fade_driver #(
    .N_LED(6), .PWM_BITS(8), .DECAY_DIV(1000), .DECAY_STEP(STP)
  ) dut_slow (
    .clk_50m(clk_50m),
    .reset  (reset),
    .enable (enable),
    .led_in (led_in),
    .led_out(led_out_slow),
    .active (active_slow)
  );

  // Behavioural model: time since enable drives tick and PWM phase.
  int         m_n = 0;
  int         m_lvl[6];
  logic [5:0] m_out = '0;
  logic       m_act = 1'b0;

  function automatic int eff(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l + LMAX) / 256;
`else
    return l;
`endif
  endfunction

  task automatic model_edge();
    if (reset || !enable) begin
      foreach (m_lvl[i]) m_lvl[i] = 0;
      m_out = '0;
      m_act = 1'b0;
      m_n   = 0;
    end else begin
      bit tick;
      int pwm;
      tick  = (m_n % DIV) == DIV - 1;
      pwm   = m_n % LMAX;
      m_act = 1'b0;
      foreach (m_lvl[i]) begin
        m_out[i] = eff(m_lvl[i]) > pwm;
        if (m_lvl[i] != 0) m_act = 1'b1;
      end
      foreach (m_lvl[i]) begin
        if (led_in[i]) m_lvl[i] = LMAX;
        else if (tick) m_lvl[i] = (m_lvl[i] - STP < 0) ? 0 : m_lvl[i] - STP;
      end
      m_n++;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    model_edge();
    @(negedge clk_50m);
    chk("model_led_out", int'(led_out), int'(m_out));
    chk("model_active", int'(active), int'(m_act));
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    led_in = '0;
    step();
    reset  = 1'b0;
  endtask

  task automatic count_active(input int cycles, output int ones);
    ones = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (active) ones++;
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [5:0] in;
    logic [5:0] eo;
    logic       ea;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int ones;
    int bad;
    int exp_duty;

    tbl[0]  = '{1'b1, 1'b1, 6'h3F, 6'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 6'h3F, 6'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 6'h3F, 6'h00, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 6'h3F, 6'h00, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 6'h3F, 6'h3F, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 6'h00, 6'h3F, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 6'h15, 6'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 6'h00, 6'h00, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 6'h01, 6'h00, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 6'h00, 6'h01, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 6'h00, 6'h01, 1'b1};

    foreach (m_lvl[i]) m_lvl[i] = 0;

    for (int v = 0; v < 11; v++) begin
      reset  = tbl[v].rst;
      enable = tbl[v].en;
      led_in = tbl[v].in;
      step();
      chk($sformatf("vec%0d_led_out", v), int'(led_out), int'(tbl[v].eo));
      chk($sformatf("vec%0d_active", v), int'(active), int'(tbl[v].ea));
    end

    // Steady hold on channel 0.
    do_reset();
    led_in = 6'h01;
    ones = 0;
    bad  = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (led_out[0]) ones++;
      if (led_out[5:1] != 0) bad++;
    end
    chk("hold_ch0_on_cycles", ones, 599);
    chk("hold_other_ch_on", bad, 0);

    // Single-cycle pulse: 64 ticks to fade, active drops one edge later.
    do_reset();
    led_in = 6'h02;
    step();
    led_in = '0;
    count_active(700, ones);
    chk("pulse_fade_active_cycles", ones, 639);

    // Pattern bit coincident with a decay tick keeps the full level.
    do_reset();
    for (int c = 0; c < 9; c++) step();
    led_in = 6'h04;
    step();
    led_in = '0;
    count_active(800, ones);
    chk("tick_collision_active_cycles", ones, 640);

    // Mid-fade enable drop, then restart timing from the first enabled edge.
    do_reset();
    led_in = 6'h08;
    step();
    led_in = '0;
    for (int c = 0; c < 395; c++) step();
    enable = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (led_out != 0 || active) bad++;
    end
    chk("disable_blanks", bad, 0);
    enable = 1'b1;
    led_in = 6'h08;
    step();
    led_in = '0;
    count_active(700, ones);
    chk("reenable_restart_active_cycles", ones, 639);

    // Mid-fade reset.
    led_in = 6'h08;
    step();
    led_in = '0;
    for (int c = 0; c < 395; c++) step();
    chk("midfade_active_before_reset", int'(active), 1);
    reset = 1'b1;
    step();
    chk("midfade_reset_led_out", int'(led_out), 0);
    chk("midfade_reset_active", int'(active), 0);
    reset = 1'b0;
    step();
    chk("after_reset_active", int'(active), 0);

    // Duty cycle at level 131 on the slow copy.
    do_reset();
    led_in = 6'h02;
    step();
    led_in = '0;
    for (int c = 0; c < 30999; c++) step();
    ones = 0;
    for (int c = 0; c < 255; c++) begin
      step();
      if (led_out_slow[1]) ones++;
    end
`ifdef LED_FADE_GAMMA_EN
    exp_duty = (131 * 131 + 255) / 256;
`else
    exp_duty = 131;
`endif
    chk("duty_level131", ones, exp_duty);
    chk("duty_slow_active", int'(active_slow), 1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      led_in = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'h00;
      enable = ($urandom_range(0, 99) != 0);
      reset  = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
